// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select encodings and register-address type.
package pipe_pkg;

    localparam int DEF_ADDR_W     = 5;
    localparam int FWD_RF         = 0;
    localparam int FWD_STAGE_BASE = 1;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/fwd_scoreboard.sv
// Busy-bit scoreboard for in-flight multi-cycle destinations, with per-address lookup.
module fwd_scoreboard
    import pipe_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_LOOKUP = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         set_en_i,
    input  logic [ADDR_W-1:0]            set_addr_i,
    input  logic                         clr_en_i,
    input  logic [ADDR_W-1:0]            clr_addr_i,
    input  logic                         flush_i,
    input  logic [NUM_LOOKUP*ADDR_W-1:0] lookup_addr_i,
    output logic [2**ADDR_W-1:0]         busy_o,
    output logic [NUM_LOOKUP-1:0]        lookup_busy_o
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] visible;

    // A register completing this cycle is served by writeback, so hide its bit from lookups.
    always_comb begin
        visible = busy_q;
        if (clr_en_i) begin
            visible[clr_addr_i] = 1'b0;
        end
    end

    always_comb begin
        lookup_busy_o = '0;
        for (int l = 0; l < NUM_LOOKUP; l++) begin
            lookup_busy_o[l] = visible[lookup_addr_i[l*ADDR_W +: ADDR_W]];
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select generation, load-use / scoreboard stall detection and stall counter.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1),
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC*ADDR_W-1:0]    ex_rs_address,
    input  logic [NUM_SRC-1:0]           ex_rs_used,
    input  logic [ADDR_W-1:0]            ex_rd_address,
    input  logic                         ex_reg_write,
    input  logic                         ex_is_mc,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_rd_address,
    input  logic [NUM_STAGES-1:0]        stage_reg_write,
    input  logic [NUM_STAGES-1:0]        stage_data_valid,
    input  logic                         mc_issue,
    input  logic                         mc_done,
    input  logic [ADDR_W-1:0]            mc_done_rd,
    input  logic                         mc_busy,
    input  logic                         mc_flush,
    input  logic                         stat_clear,
    output logic [NUM_SRC*SEL_W-1:0]     forward_sel,
    output logic                         stall,
    output logic [2**ADDR_W-1:0]         sb_busy,
    output logic [CNT_W-1:0]             stall_count
);

    logic                               loadUse;
    logic [NUM_SRC-1:0]                 found;
    logic [NUM_SRC:0]                   lookupBusy;
    logic                               rawHazard;
    logic                               wawHazard;
    logic                               structHazard;
    logic                               issueOk;
    logic [CNT_W-1:0]                   stallCnt_q;
    logic [CNT_W-1:0]                   stallCnt_d;

    // Youngest matching producer wins; only that producer's data_valid decides load-use.
    always_comb begin
        forward_sel = '0;
        loadUse     = 1'b0;
        found       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            forward_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (!found[i] && ex_rs_used[i] &&
                    (ex_rs_address[i*ADDR_W +: ADDR_W] != '0) &&
                    stage_reg_write[k] &&
                    (stage_rd_address[k*ADDR_W +: ADDR_W] == ex_rs_address[i*ADDR_W +: ADDR_W])) begin
                    forward_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_STAGE_BASE + k);
                    found[i] = 1'b1;
                    if (!stage_data_valid[k]) begin
                        loadUse = 1'b1;
                    end
                end
            end
        end
    end

    fwd_scoreboard #(
        .ADDR_W     (ADDR_W),
        .NUM_LOOKUP (NUM_SRC + 1)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .set_en_i      (issueOk),
        .set_addr_i    (ex_rd_address),
        .clr_en_i      (mc_done),
        .clr_addr_i    (mc_done_rd),
        .flush_i       (mc_flush),
        .lookup_addr_i ({ex_rd_address, ex_rs_address}),
        .busy_o        (sb_busy),
        .lookup_busy_o (lookupBusy)
    );

    assign rawHazard    = |(lookupBusy[NUM_SRC-1:0] & ex_rs_used);
    assign wawHazard    = ex_reg_write && lookupBusy[NUM_SRC];
    assign structHazard = ex_is_mc && mc_busy;
    assign stall        = loadUse || rawHazard || wawHazard || structHazard;
    assign issueOk      = mc_issue && !stall && ex_reg_write && (ex_rd_address != '0);

    // Clear has priority; otherwise count stalled cycles and hold at all-ones.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stat_clear) begin
            stallCnt_d = '0;
        end else if (stall && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_count = stallCnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (two sources, two producer stages, 4-bit counter).
module tb_fwd_hazard_unit;
    import pipe_pkg::*;

    localparam int ADDR_W     = 5;
    localparam int NUM_SRC    = 2;
    localparam int NUM_STAGES = 2;
    localparam int SEL_W      = 2;
    localparam int CNT_W      = 4;

    logic                         clk;
    logic                         rst_n;
    logic [NUM_SRC*ADDR_W-1:0]    ex_rs_address;
    logic [NUM_SRC-1:0]           ex_rs_used;
    logic [ADDR_W-1:0]            ex_rd_address;
    logic                         ex_reg_write;
    logic                         ex_is_mc;
    logic [NUM_STAGES*ADDR_W-1:0] stage_rd_address;
    logic [NUM_STAGES-1:0]        stage_reg_write;
    logic [NUM_STAGES-1:0]        stage_data_valid;
    logic                         mc_issue;
    logic                         mc_done;
    logic [ADDR_W-1:0]            mc_done_rd;
    logic                         mc_busy;
    logic                         mc_flush;
    logic                         stat_clear;
    logic [NUM_SRC*SEL_W-1:0]     forward_sel;
    logic                         stall;
    logic [2**ADDR_W-1:0]         sb_busy;
    logic [CNT_W-1:0]             stall_count;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit #(
        .ADDR_W     (ADDR_W),
        .NUM_SRC    (NUM_SRC),
        .NUM_STAGES (NUM_STAGES),
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_rs_address    (ex_rs_address),
        .ex_rs_used       (ex_rs_used),
        .ex_rd_address    (ex_rd_address),
        .ex_reg_write     (ex_reg_write),
        .ex_is_mc         (ex_is_mc),
        .stage_rd_address (stage_rd_address),
        .stage_reg_write  (stage_reg_write),
        .stage_data_valid (stage_data_valid),
        .mc_issue         (mc_issue),
        .mc_done          (mc_done),
        .mc_done_rd       (mc_done_rd),
        .mc_busy          (mc_busy),
        .mc_flush         (mc_flush),
        .stat_clear       (stat_clear),
        .forward_sel      (forward_sel),
        .stall            (stall),
        .sb_busy          (sb_busy),
        .stall_count      (stall_count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Idle all inputs: nothing used, nothing writing, no multi-cycle activity.
    task automatic applyStimulus();
        ex_rs_address    = '0;
        ex_rs_used       = '0;
        ex_rd_address    = '0;
        ex_reg_write     = 1'b0;
        ex_is_mc         = 1'b0;
        stage_rd_address = '0;
        stage_reg_write  = '0;
        stage_data_valid = '1;
        mc_issue         = 1'b0;
        mc_done          = 1'b0;
        mc_done_rd       = '0;
        mc_busy          = 1'b0;
        mc_flush         = 1'b0;
        stat_clear       = 1'b0;
        #1;
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus();
        #10;
        checkOutput("reset_sb_busy", sb_busy, 32'h0);
        checkOutput("reset_count", 32'(stall_count), 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);
        checkOutput("reset_sel", 32'(forward_sel), 32'h0);
        rst_n = 1'b1;
        tick();

        // Both stages write r5: youngest wins
        stage_rd_address = {5'd5, 5'd5};
        stage_reg_write  = 2'b11;
        ex_rs_address    = {5'd0, 5'd5};
        ex_rs_used       = 2'b01;
        #1;
        checkOutput("youngest_sel", 32'(forward_sel), 32'h1);
        checkOutput("youngest_stall", 32'(stall), 32'h0);
        stage_rd_address = {5'd5, 5'd6};
        ex_rs_address    = {5'd5, 5'd5};
        ex_rs_used       = 2'b11;
        #1;
        checkOutput("memwb_only_sel", 32'(forward_sel), 32'hA);
        stage_rd_address = {5'd5, 5'd5};
        stage_reg_write  = 2'b10;
        #1;
        checkOutput("stage0_nowrite_sel", 32'(forward_sel), 32'hA);

        // Load in EX/MEM (not valid) with valid older match on r7
        applyStimulus();
        stage_rd_address = {5'd7, 5'd7};
        stage_reg_write  = 2'b11;
        stage_data_valid = 2'b10;
        ex_rs_address    = {5'd7, 5'd0};
        ex_rs_used       = 2'b10;
        #1;
        checkOutput("loaduse_stall", 32'(stall), 32'h1);
        checkOutput("loaduse_sel", 32'(forward_sel), 32'h4);
        tick();
        checkOutput("loaduse_count1", 32'(stall_count), 32'h1);
        tick();
        checkOutput("loaduse_count2", 32'(stall_count), 32'h2);
        stage_data_valid = 2'b11;
        #1;
        checkOutput("load_ready_stall", 32'(stall), 32'h0);
        checkOutput("load_ready_sel", 32'(forward_sel), 32'h4);
        tick();
        checkOutput("load_ready_count", 32'(stall_count), 32'h2);

        // x0 never forwards; unused operand never forwards
        applyStimulus();
        stage_rd_address = {5'd0, 5'd0};
        stage_reg_write  = 2'b11;
        stage_data_valid = 2'b00;
        ex_rs_used       = 2'b01;
        #1;
        checkOutput("x0_sel", 32'(forward_sel), 32'h0);
        checkOutput("x0_stall", 32'(stall), 32'h0);
        stage_rd_address = {5'd5, 5'd5};
        ex_rs_address    = {5'd0, 5'd5};
        ex_rs_used       = 2'b00;
        #1;
        checkOutput("unused_sel", 32'(forward_sel), 32'h0);

        // Multi-cycle issue to r9, RAW stall, completion bypass
        applyStimulus();
        ex_rd_address = 5'd9;
        ex_reg_write  = 1'b1;
        ex_is_mc      = 1'b1;
        mc_issue      = 1'b1;
        tick();
        checkOutput("issue9_busy", sb_busy, 32'h0000_0200);
        applyStimulus();
        ex_rs_address = {5'd0, 5'd9};
        ex_rs_used    = 2'b01;
        #1;
        checkOutput("raw9_stall", 32'(stall), 32'h1);
        tick();
        checkOutput("raw9_count", 32'(stall_count), 32'h3);
        mc_done    = 1'b1;
        mc_done_rd = 5'd9;
        #1;
        checkOutput("done9_stall", 32'(stall), 32'h0);
        checkOutput("done9_still_busy", sb_busy, 32'h0000_0200);
        tick();
        checkOutput("done9_cleared", sb_busy, 32'h0);

        // Issue while stalled is ignored; issue to x0 is ignored
        applyStimulus();
        stage_rd_address = {5'd0, 5'd4};
        stage_reg_write  = 2'b01;
        stage_data_valid = 2'b00;
        ex_rs_address    = {5'd0, 5'd4};
        ex_rs_used       = 2'b01;
        ex_rd_address    = 5'd10;
        ex_reg_write     = 1'b1;
        mc_issue         = 1'b1;
        tick();
        checkOutput("stalled_issue_busy", sb_busy, 32'h0);
        checkOutput("stalled_issue_count", 32'(stall_count), 32'h4);
        applyStimulus();
        ex_reg_write = 1'b1;
        mc_issue     = 1'b1;
        mc_done      = 1'b1;
        mc_done_rd   = 5'd11;
        tick();
        checkOutput("x0_issue_busy", sb_busy, 32'h0);

        // Same-cycle issue/done on r3 leaves it set
        applyStimulus();
        ex_rd_address = 5'd3;
        ex_reg_write  = 1'b1;
        mc_issue      = 1'b1;
        tick();
        checkOutput("issue3_busy", sb_busy, 32'h0000_0008);
        mc_done    = 1'b1;
        mc_done_rd = 5'd3;
        #1;
        checkOutput("issue_done3_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("issue_done3_busy", sb_busy, 32'h0000_0008);
        applyStimulus();
        ex_rd_address = 5'd9;
        ex_reg_write  = 1'b1;
        mc_issue      = 1'b1;
        tick();
        checkOutput("issue9b_busy", sb_busy, 32'h0000_0208);
        mc_issue = 1'b0;
        #1;
        checkOutput("waw9_stall", 32'(stall), 32'h1);
        applyStimulus();
        ex_is_mc = 1'b1;
        mc_busy  = 1'b1;
        #1;
        checkOutput("struct_stall", 32'(stall), 32'h1);

        // Flush overrides a concurrent issue
        applyStimulus();
        ex_rd_address = 5'd12;
        ex_reg_write  = 1'b1;
        mc_issue      = 1'b1;
        mc_flush      = 1'b1;
        tick();
        checkOutput("flush_busy", sb_busy, 32'h0);

        // Saturation at 15, then clear beats increment
        applyStimulus();
        ex_is_mc = 1'b1;
        mc_busy  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
        end
        checkOutput("sat_count", 32'(stall_count), 32'hF);
        stat_clear = 1'b1;
        tick();
        checkOutput("clear_count", 32'(stall_count), 32'h0);
        stat_clear = 1'b0;
        tick();
        checkOutput("after_clear_count", 32'(stall_count), 32'h1);

        // Asynchronous reset mid-operation
        applyStimulus();
        ex_rd_address = 5'd9;
        ex_reg_write  = 1'b1;
        mc_issue      = 1'b1;
        tick();
        applyStimulus();
        ex_is_mc = 1'b1;
        mc_busy  = 1'b1;
        tick();
        checkOutput("pre_reset_busy", sb_busy, 32'h0000_0200);
        checkOutput("pre_reset_count", 32'(stall_count), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", sb_busy, 32'h0);
        checkOutput("async_reset_count", 32'(stall_count), 32'h0);
        checkOutput("reset_comb_stall", 32'(stall), 32'h1);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised next-generation forwarding and hazard unit for the in-order RISC-V pipeline, sitting beside the EX stage.
- Produces one forwarding select per EX source operand from NUM_STAGES downstream producer stages, youngest producer first.
- Detects load-use hazards. Tracks in-flight multi-cycle (mul/div) destinations in a scoreboard and raises a stall for RAW/WAW hazards against them.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- ADDR_W, 5, register address width.
- NUM_SRC, 2, number of EX source operands checked.
- NUM_STAGES, 2, forwarding producer stages; index 0 is youngest (EX/MEM), then MEM/WB, ...
- SEL_W, $clog2(NUM_STAGES+1), forwarding select width.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_rs_address  in  NUM_SRC*ADDR_W  source addresses; operand i at bits [i*ADDR_W +: ADDR_W]
- ex_rs_used  in  NUM_SRC  operand i actually read
- ex_rd_address  in  ADDR_W  EX destination
- ex_reg_write  in  1  EX instruction writes rd
- ex_is_mc  in  1  EX instruction is multi-cycle
- stage_rd_address  in  NUM_STAGES*ADDR_W  producer destinations
- stage_reg_write  in  NUM_STAGES  producer writes rd
- stage_data_valid  in  NUM_STAGES  producer result available this cycle (0 for a load still in MEM)
- mc_issue  in  1  multi-cycle op issued this cycle
- mc_done  in  1  multi-cycle op writing back this cycle
- mc_done_rd  in  ADDR_W  destination of the completing op
- mc_busy  in  1  multi-cycle unit cannot accept a new op
- mc_flush  in  1  abort all in-flight multi-cycle ops
- stat_clear  in  1  clear stall counter
- forward_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = stage k-1
- stall  out  1  hold IF/ID/EX, insert bubble
- sb_busy  out  2**ADDR_W  scoreboard vector (debug)
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Forwarding (combinational):
  - Operand i matches stage k when ex_rs_used[i], ex_rs_address[i]!=0, stage_reg_write[k], and stage_rd_address[k]==ex_rs_address[i].
  - forward_sel[i] = k+1 for the lowest matching k; 0 if no stage matches.
  - An older stage never overrides a younger match. A non-matching stage never clears a select.
- Load-use stall: raised when the selected (youngest) match has stage_data_valid=0. An older valid match does not suppress the stall.
- Scoreboard: register sb_busy, reset to 0.
  - Next state: clear bit mc_done_rd when mc_done, then set bit ex_rd_address when issue_ok.
  - issue_ok = mc_issue && !stall && ex_reg_write && ex_rd_address!=0.
  - Issue and done on the same address in the same cycle: the bit ends up set.
  - mc_done on a non-busy bit: no effect.
  - mc_flush: all bits 0 next cycle; overrides issue and done.
  - mc_issue while stall=1 is ignored (no bit set).
  - Bit 0 never set.
- Scoreboard stall (combinational, from the current sb_busy):
  - RAW: any used operand whose address bit is busy.
  - WAW: ex_reg_write with the ex_rd_address bit busy.
  - Structural: ex_is_mc && mc_busy.
  - The bit of a register completing this cycle (mc_done) is treated as not busy; the writeback stage supplies the value.
- stall = OR of load-use, RAW, WAW and structural terms. Forward selects remain valid while stalled.
- stall_count: reset 0. On stat_clear it goes to 0 (priority over increment). Otherwise it increments each cycle stall=1 and saturates at all-ones.
- Reset mid-operation: sb_busy, stall_count -> 0 immediately; combinational outputs follow inputs.
- Latency: forward_sel and stall 0-cycle; scoreboard updates visible the next cycle.

Decomposition:
- Shared package pipe_pkg: select encodings FWD_RF=0, FWD_STAGE_BASE=1; ADDR_W default; reg-address typedef.
- One sub-module, fwd_scoreboard: busy vector, set/clear/flush logic, per-address lookup. Priority encoder and counter stay in the top.

Test Plan:
- EX/MEM rd=5 wr=1 valid, MEM/WB rd=5 wr=1, ex_rs1=5 -> forward_sel[0]=1 (not 2), stall=0; a MEM/WB-only match gives 2.
- Load in stage 0 rd=7 data_valid=0, ex_rs2=7 used -> stall=1, stall_count +1 per cycle; data_valid=1 next -> stall=0, sel[1]=1.
- ex_rs1=0 with all stages rd=0 wr=1 -> sel=0, stall=0; ex_rs_used[0]=0 with rs1 matching -> sel=0.
- mc_issue rd=9 -> sb_busy[9]=1 next cycle; ex_rs1=9 -> stall=1; mc_done rd=9 -> stall=0 that cycle, bit cleared next.
- Same-cycle issue rd=3 and done rd=3 -> sb_busy[3]=1; mc_flush with bits 3,9 set -> all 0 next cycle; rst_n low mid-op -> sb_busy=0, stall_count=0 asynchronously.
- CNT_W=4, stall held 20 cycles -> stall_count saturates at 15; stat_clear with stall=1 -> 0.
